// File: rtl/data_mem_port.sv
// RV32 data-memory port: byte/half/word loads and stores over a word-organised synchronous RAM.
// Build option MISALIGNED_SPLIT_EN: word-crossing misaligned accesses complete over two cycles.
module data_mem_port #(
    parameter int DEPTH_WORDS = 4096,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              fault
);

    localparam int                IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [2:0] f3);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{raw[7]}}, raw[7:0]};
            3'b001:  r = {{16{raw[15]}}, raw[15:0]};
            3'b100:  r = {24'd0, raw[7:0]};
            3'b101:  r = {16'd0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    logic [1:0]        off;
    logic [4:0]        sh;
    logic [ADDR_W-1:0] word_lo;
    logic              is_h;
    logic              is_w;
    logic              f3_ok;
    logic              lo_oob;
    logic              hi_oob;
    logic              mis_bad;
    logic              req_fault;
    logic              accept;
    logic              acc_ok;
    logic [3:0]        nmask;
    logic [3:0]        lo_mask;
    logic [31:0]       lo_data;
    logic [31:0]       rd_word;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_en;
    logic [3:0]        wr_mask;
    logic [31:0]       wr_data;
    logic [31:0]       load_raw;
    logic [2:0]        load_f3;

    assign off     = addr[1:0];
    assign sh      = {off, 3'b000};
    assign word_lo = {2'b00, addr[ADDR_W-1:2]};
    assign is_h    = (funct3[1:0] == 2'b01);
    assign is_w    = (funct3[1:0] == 2'b10);
    assign f3_ok   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b101);
    assign lo_oob  = (word_lo >= DEPTH_L);
    assign nmask   = is_w ? 4'b1111 : (is_h ? 4'b0011 : 4'b0001);
    assign lo_mask = nmask << off;
    assign lo_data = wdata << sh;

`ifdef MISALIGNED_SPLIT_EN
    typedef enum logic {IDLE, SPLIT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] word_hi;
    logic              crosses;
    logic [3:0]        hi_mask;
    logic [31:0]       hi_data;
    logic [IDX_W-1:0]  hi_idx_p0;
    logic [3:0]        hi_mask_p0;
    logic [31:0]       hi_data_p0;
    logic [31:0]       lo_word_p0;
    logic [4:0]        sh_p0;
    logic [2:0]        f3_p0;
    logic              we_p0;

    // word_lo has two zero top bits, so +1 cannot wrap back into range
    assign word_hi = word_lo + ADDR_W'(1);
    assign crosses = (is_h && off == 2'd3) || (is_w && off != 2'd0);
    assign hi_oob  = crosses && (word_hi >= DEPTH_L);
    assign mis_bad = 1'b0;
    assign hi_mask = nmask >> (3'd4 - {1'b0, off});
    assign hi_data = wdata >> (6'd32 - {1'b0, sh});
    assign busy    = (state == SPLIT);
`else
    assign hi_oob  = 1'b0;
    assign mis_bad = (is_h && off[0]) || (is_w && off != 2'd0);
    assign busy    = 1'b0;
`endif

    assign accept    = rst && req_valid && !busy;
    assign req_fault = !f3_ok || mis_bad || lo_oob || hi_oob;
    assign acc_ok    = accept && !req_fault;

    always_comb begin
        rd_idx   = word_lo[IDX_W-1:0];
        wr_idx   = word_lo[IDX_W-1:0];
        wr_en    = acc_ok && we;
        wr_mask  = lo_mask;
        wr_data  = lo_data;
        load_raw = rd_word >> sh;
        load_f3  = funct3;
`ifdef MISALIGNED_SPLIT_EN
        if (state == SPLIT) begin
            rd_idx   = hi_idx_p0;
            wr_idx   = hi_idx_p0;
            wr_en    = rst && we_p0;
            wr_mask  = hi_mask_p0;
            wr_data  = hi_data_p0;
            load_raw = (lo_word_p0 >> sh_p0) | (rd_word << (6'd32 - {1'b0, sh_p0}));
            load_f3  = f3_p0;
        end
`endif
    end

    assign rd_word = mem[rd_idx];

    // RAM write stage: byte lanes under mask, contents never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

`ifdef MISALIGNED_SPLIT_EN
    // Split hold stage: low-word lanes and high-word write plan for the second cycle
    always_ff @(posedge clk) begin
        if (acc_ok && crosses) begin
            hi_idx_p0  <= word_hi[IDX_W-1:0];
            hi_mask_p0 <= hi_mask;
            hi_data_p0 <= hi_data;
            lo_word_p0 <= rd_word;
            sh_p0      <= sh;
            f3_p0      <= funct3;
            we_p0      <= we;
        end
    end
`endif

    // Result stage: registered load data, valid and fault
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
`ifdef MISALIGNED_SPLIT_EN
            state  <= IDLE;
`endif
            rvalid <= 1'b0;
            rdata  <= 32'd0;
            fault  <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            fault  <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            if (state == SPLIT) begin
                state <= IDLE;
                if (!we_p0) begin
                    rvalid <= 1'b1;
                    rdata  <= load_extend(load_raw, load_f3);
                end
            end else if (accept) begin
                if (req_fault) begin
                    fault <= 1'b1;
                    rdata <= 32'd0;
                end else if (crosses) begin
                    state <= SPLIT;
                end else if (!we) begin
                    rvalid <= 1'b1;
                    rdata  <= load_extend(load_raw, load_f3);
                end
            end
`else
            if (accept) begin
                if (req_fault) begin
                    fault <= 1'b1;
                    rdata <= 32'd0;
                end else if (!we) begin
                    rvalid <= 1'b1;
                    rdata  <= load_extend(load_raw, load_f3);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port with a queue of expected port responses.
module tb_data_mem_port;

    localparam int         DEPTH = 16;
    localparam logic [2:0] F_B   = 3'b000;
    localparam logic [2:0] F_H   = 3'b001;
    localparam logic [2:0] F_W   = 3'b010;
    localparam logic [2:0] F_BU  = 3'b100;
    localparam logic [2:0] F_HU  = 3'b101;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        req_valid = 1'b0;
    logic        we        = 1'b0;
    logic [2:0]  funct3    = 3'b000;
    logic [31:0] addr      = 32'd0;
    logic [31:0] wdata     = 32'd0;
    logic        busy;
    logic        rvalid;
    logic [31:0] rdata;
    logic        fault;

    data_mem_port #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        rvalid;
        logic        fault;
        logic        chk_data;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] er, input logic ev, input logic ef);
        exp_t e;
        e.tag      = tag;
        e.rdata    = er;
        e.rvalid   = ev;
        e.fault    = ef;
        e.chk_data = ev || ef;
        exp_q.push_back(e);
    endtask

    task automatic score();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            check({e.tag, ".rvalid"}, 32'(rvalid), 32'(e.rvalid));
            check({e.tag, ".fault"},  32'(fault),  32'(e.fault));
            check({e.tag, ".busy"},   32'(busy),   32'd0);
            if (e.chk_data) check({e.tag, ".rdata"}, rdata, e.rdata);
        end
    endtask

    task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        we        = w;
        funct3    = f3;
        addr      = a;
        wdata     = d;
    endtask

    // called on a falling edge; leaves on the falling edge after acceptance
    task automatic access(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] er, input logic ev, input logic ef);
        push(tag, er, ev, ef);
        drive(w, f3, a, d);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        score();
    endtask

`ifdef MISALIGNED_SPLIT_EN
    task automatic split_access(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] er);
        push(tag, er, !w, 1'b0);
        drive(w, f3, a, d);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".busy_mid"},   32'(busy),   32'd1);
        check({tag, ".rvalid_mid"}, 32'(rvalid), 32'd0);
        drive(1'b1, F_W, 32'd8, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        score();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        #1;
        check("reset.rdata",  rdata,         32'd0);
        check("reset.rvalid", 32'(rvalid),   32'd0);
        check("reset.fault",  32'(fault),    32'd0);
        check("reset.busy",   32'(busy),     32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < DEPTH; i++) dut.mem[i] <= 32'(i);
        access("lw8",  1'b0, F_W, 32'd8,  32'd0, 32'd2, 1'b1, 1'b0);
        access("lw16", 1'b0, F_W, 32'd16, 32'd0, 32'd4, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("lw16.rvalid_drop", 32'(rvalid), 32'd0);

        dut.mem[0] <= 32'h00000080;
        dut.mem[3] <= 32'hFE008001;
        access("lb0",   1'b0, F_B,  32'd0,  32'd0, 32'hFFFFFF80, 1'b1, 1'b0);
        access("lbu0",  1'b0, F_BU, 32'd0,  32'd0, 32'h00000080, 1'b1, 1'b0);
        access("lhu2",  1'b0, F_HU, 32'd2,  32'd0, 32'h00000000, 1'b1, 1'b0);
        access("lh12",  1'b0, F_H,  32'd12, 32'd0, 32'hFFFF8001, 1'b1, 1'b0);
        access("lhu12", 1'b0, F_HU, 32'd12, 32'd0, 32'h00008001, 1'b1, 1'b0);
        access("lh14",  1'b0, F_H,  32'd14, 32'd0, 32'hFFFFFE00, 1'b1, 1'b0);
        access("lb13",  1'b0, F_B,  32'd13, 32'd0, 32'hFFFFFF80, 1'b1, 1'b0);
        access("lb15",  1'b0, F_B,  32'd15, 32'd0, 32'hFFFFFFFE, 1'b1, 1'b0);

        dut.mem[0] <= 32'd0;
        access("sh2",  1'b1, F_H, 32'd2, 32'h1234BEEF, 32'd0,        1'b0, 1'b0);
        access("lw0",  1'b0, F_W, 32'd0, 32'd0,        32'hBEEF0000, 1'b1, 1'b0);
        access("sb5",  1'b1, F_B, 32'd5, 32'h000000A5, 32'd0,        1'b0, 1'b0);
        access("lw4",  1'b0, F_W, 32'd4, 32'd0,        32'h0000A501, 1'b1, 1'b0);
        access("sw8",  1'b1, F_W, 32'd8, 32'hCAFEF00D, 32'd0,        1'b0, 1'b0);
        access("lw8b", 1'b0, F_W, 32'd8, 32'd0,        32'hCAFEF00D, 1'b1, 1'b0);

        access("f3_011.load",  1'b0, 3'b011, 32'd0, 32'd0,        32'd0,        1'b0, 1'b1);
        access("f3_110.store", 1'b1, 3'b110, 32'd0, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b1);
        access("f3_111.load",  1'b0, 3'b111, 32'd0, 32'd0,        32'd0,        1'b0, 1'b1);
        access("f3.lw0",       1'b0, F_W,    32'd0, 32'd0,        32'hBEEF0000, 1'b1, 1'b0);

        dut.mem[0] <= 32'h44332211;
        dut.mem[1] <= 32'h88776655;
        dut.mem[2] <= 32'd2;
`ifdef MISALIGNED_SPLIT_EN
        split_access("mis.lw1", 1'b0, F_W, 32'd1, 32'd0, 32'h55443322);
        access("mis.lw8_ignored", 1'b0, F_W, 32'd8, 32'd0, 32'd2, 1'b1, 1'b0);
        access("mis.lh1", 1'b0, F_H, 32'd1, 32'd0, 32'h00003322, 1'b1, 1'b0);
        split_access("mis.lhu3", 1'b0, F_HU, 32'd3, 32'd0, 32'h00005544);
        split_access("mis.sw2", 1'b1, F_W, 32'd2, 32'hAABBCCDD, 32'd0);
        check("mis.sw2.mem0", dut.mem[0], 32'hCCDD2211);
        check("mis.sw2.mem1", dut.mem[1], 32'h8877AABB);
`else
        access("mis.lw1",  1'b0, F_W,  32'd1, 32'd0,        32'd0, 1'b0, 1'b1);
        access("mis.sw1",  1'b1, F_W,  32'd1, 32'hAABBCCDD, 32'd0, 1'b0, 1'b1);
        check("mis.sw1.mem0", dut.mem[0], 32'h44332211);
        check("mis.sw1.mem1", dut.mem[1], 32'h88776655);
        access("mis.lh1",  1'b0, F_H,  32'd1, 32'd0,        32'd0, 1'b0, 1'b1);
        access("mis.lhu3", 1'b0, F_HU, 32'd3, 32'd0,        32'd0, 1'b0, 1'b1);
`endif

        dut.mem[0]  <= 32'h11111111;
        dut.mem[15] <= 32'd15;
        access("oob.sw64", 1'b1, F_W, 32'd64, 32'h99999999, 32'd0, 1'b0, 1'b1);
        check("oob.sw64.mem0", dut.mem[0], 32'h11111111);
        access("oob.lw64",    1'b0, F_W,  32'd64,     32'd0, 32'd0,  1'b0, 1'b1);
        access("oob.lw4096",  1'b0, F_W,  32'h1000,   32'd0, 32'd0,  1'b0, 1'b1);
        access("oob.lw60",    1'b0, F_W,  32'd60,     32'd0, 32'd15, 1'b1, 1'b0);
        access("oob.lw62",    1'b0, F_W,  32'd62,     32'd0, 32'd0,  1'b0, 1'b1);
        access("oob.lhu62",   1'b0, F_HU, 32'd62,     32'd0, 32'd0,  1'b1, 1'b0);

        access("arst.lw60", 1'b0, F_W, 32'd60, 32'd0, 32'd15, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("arst.rvalid", 32'(rvalid), 32'd0);
        check("arst.rdata",  rdata,       32'd0);
        @(negedge clk);
        rst = 1'b1;

        access("pre.lw60", 1'b0, F_W, 32'd60, 32'd0, 32'd15, 1'b1, 1'b0);
        dut.mem[0] <= 32'h44332211;
        dut.mem[1] <= 32'h88776655;
        drive(1'b1, F_W, 32'd3, 32'hAABBCCDD);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
        check("srst.busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("srst.busy",   32'(busy),   32'd0);
        check("srst.rvalid", 32'(rvalid), 32'd0);
        check("srst.fault",  32'(fault),  32'd0);
        check("srst.rdata",  rdata,       32'd0);
        @(negedge clk);
        rst = 1'b1;
        check("srst.mem0", dut.mem[0], 32'hDD332211);
        check("srst.mem1", dut.mem[1], 32'h88776655);
`else
        check("srst.fault_before", 32'(fault), 32'd1);
        check("srst.busy_before",  32'(busy),  32'd0);
        rst = 1'b0;
        #1;
        check("srst.fault", 32'(fault), 32'd0);
        check("srst.rdata", rdata,      32'd0);
        @(negedge clk);
        rst = 1'b1;
        check("srst.mem0", dut.mem[0], 32'h44332211);
        check("srst.mem1", dut.mem[1], 32'h88776655);
`endif
        access("post.lw4", 1'b0, F_W, 32'd4, 32'd0, 32'h88776655, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
